// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator over a raster image.
// Ports: clk, rst (sync, active-high), in_valid/in_data (signed pixel,
//   raster order), win0..win8 (row-major window, win8 = newest pixel),
//   out_valid (window valid), frame_done (pulse with last window).
module conv_window_gen #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic signed [7:0] in_data,
    output logic signed [7:0] win0,
    output logic signed [7:0] win1,
    output logic signed [7:0] win2,
    output logic signed [7:0] win3,
    output logic signed [7:0] win4,
    output logic signed [7:0] win5,
    output logic signed [7:0] win6,
    output logic signed [7:0] win7,
    output logic signed [7:0] win8,
    output logic              out_valid,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // line0 holds the row above the current one, line1 the row above that
    logic signed [7:0] line0 [IMG_W];
    logic signed [7:0] line1 [IMG_W];

    logic signed [7:0] lb0_rd;
    logic signed [7:0] lb1_rd;

    // two previous columns of the window; the newest column comes
    // straight from the line-buffer reads and in_data
    logic signed [7:0] top_a, top_b;
    logic signed [7:0] mid_a, mid_b;
    logic signed [7:0] bot_a, bot_b;

    logic last_col;
    logic last_row;
    logic emit;

    assign lb0_rd   = line0[col];
    assign lb1_rd   = line1[col];
    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);
    // windows only once two full rows and two columns precede this pixel;
    // this also keeps stale line-buffer data from a prior frame out
    assign emit     = (row >= ROW_TWO) && (col >= COL_TWO);

    // line buffers carry no reset: emit gating hides stale contents
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            line0[col] <= in_data;
            line1[col] <= lb0_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            top_a      <= '0;
            top_b      <= '0;
            mid_a      <= '0;
            mid_b      <= '0;
            bot_a      <= '0;
            bot_b      <= '0;
            win0       <= '0;
            win1       <= '0;
            win2       <= '0;
            win3       <= '0;
            win4       <= '0;
            win5       <= '0;
            win6       <= '0;
            win7       <= '0;
            win8       <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                top_a <= top_b;
                top_b <= lb1_rd;
                mid_a <= mid_b;
                mid_b <= lb0_rd;
                bot_a <= bot_b;
                bot_b <= in_data;
                // outputs load only on a real window so they hold otherwise
                if (emit) begin
                    out_valid  <= 1'b1;
                    frame_done <= last_col && last_row;
                    win0       <= top_a;
                    win1       <= top_b;
                    win2       <= lb1_rd;
                    win3       <= mid_a;
                    win4       <= mid_b;
                    win5       <= lb0_rd;
                    win6       <= bot_a;
                    win7       <= bot_b;
                    win8       <= in_data;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen.
// Three instances: 4x4 and 5x3 with hand tables, 28x28 with a raster model.
module tb_conv_window_gen;

    typedef logic [8:0][7:0] win_t;
    typedef struct {
        win_t w;
        logic f;
        int   t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]        rst_v = 3'b111;
    logic [2:0]        iv    = 3'b000;
    logic signed [7:0] id [3];
    win_t              wa, wb, wc;
    logic [2:0]        ov, fd;

    int total = 0;
    int bad   = 0;

    int   W [3] = '{4, 5, 28};
    int   H [3] = '{4, 3, 28};
    int   pr [3];
    int   pc [3];
    int   hidx [3];
    logic [7:0] img [28][28];
    win_t h4 [8];
    win_t h5 [3];
    win_t last [3];
    exp_t qa[$], qb[$], qc[$];

    conv_window_gen #(.IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst_v[0]), .in_valid(iv[0]), .in_data(id[0]),
        .win0(wa[0]), .win1(wa[1]), .win2(wa[2]),
        .win3(wa[3]), .win4(wa[4]), .win5(wa[5]),
        .win6(wa[6]), .win7(wa[7]), .win8(wa[8]),
        .out_valid(ov[0]), .frame_done(fd[0])
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(3)) u_b (
        .clk(clk), .rst(rst_v[1]), .in_valid(iv[1]), .in_data(id[1]),
        .win0(wb[0]), .win1(wb[1]), .win2(wb[2]),
        .win3(wb[3]), .win4(wb[4]), .win5(wb[5]),
        .win6(wb[6]), .win7(wb[7]), .win8(wb[8]),
        .out_valid(ov[1]), .frame_done(fd[1])
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28)) u_c (
        .clk(clk), .rst(rst_v[2]), .in_valid(iv[2]), .in_data(id[2]),
        .win0(wc[0]), .win1(wc[1]), .win2(wc[2]),
        .win3(wc[3]), .win4(wc[4]), .win5(wc[5]),
        .win6(wc[6]), .win7(wc[7]), .win8(wc[8]),
        .out_valid(ov[2]), .frame_done(fd[2])
    );

    function automatic win_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5,
                                input int a6, input int a7, input int a8);
        win_t w;
        w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2);
        w[3] = 8'(a3); w[4] = 8'(a4); w[5] = 8'(a5);
        w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
        return w;
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h", name, k, act, req);
        end
    endfunction

    function automatic void push(input int k, input exp_t e);
        case (k)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic exp_t pop(input int k);
        case (k)
            0:       return qa.pop_front();
            1:       return qb.pop_front();
            default: return qc.pop_front();
        endcase
    endfunction

    function automatic win_t getw(input int k);
        case (k)
            0:       return wa;
            1:       return wb;
            default: return wc;
        endcase
    endfunction

    // monitor: pops on every presented window, checks hold otherwise
    exp_t me;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                last[k] = '0;
            end else if (ov[k]) begin
                if (qsize(k) == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_window dut%0d: got out_valid=1 want 0 at cyc %0d",
                             k, cyc);
                end else begin
                    me = pop(k);
                    chk("window", k, 80'(getw(k)), 80'(me.w));
                    chk("frame_done", k, 80'(fd[k]), 80'(me.f));
                    chk("latency", k, 80'(cyc), 80'(me.t));
                end
                last[k] = getw(k);
            end else begin
                chk("hold", k, {getw(k), fd[k]}, {last[k], 1'b0});
            end
        end
    end

    task automatic pix(input int k, input int d);
        exp_t e;
        @(negedge clk);
        iv[k] = 1'b1;
        id[k] = 8'(d);
        if (k == 2) img[pr[k]][pc[k]] = 8'(d);
        if (pr[k] >= 2 && pc[k] >= 2) begin
            if (k == 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[3*i+j] = img[pr[k]-2+i][pc[k]-2+j];
            end else if (k == 0) begin
                e.w = h4[hidx[0]];
            end else begin
                e.w = h5[hidx[1]];
            end
            hidx[k]++;
            e.f = (pr[k] == H[k] - 1) && (pc[k] == W[k] - 1);
            e.t = cyc + 1;
            push(k, e);
        end
        if (pc[k] == W[k] - 1) begin
            pc[k] = 0;
            pr[k] = (pr[k] == H[k] - 1) ? 0 : pr[k] + 1;
        end else begin
            pc[k]++;
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    // in_valid held high during reset must be ignored
    task automatic do_reset(input int k);
        @(negedge clk);
        rst_v[k] = 1'b1;
        iv[k]    = 1'b1;
        id[k]    = 8'sd55;
        @(negedge clk);
        chk("reset_out", k, 80'({getw(k), ov[k], fd[k]}), 80'(0));
        @(negedge clk);
        rst_v[k] = 1'b0;
        iv[k]    = 1'b0;
        pr[k]    = 0;
        pc[k]    = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            id[k]   = '0;
            pr[k]   = 0;
            pc[k]   = 0;
            hidx[k] = 0;
            last[k] = '0;
        end
        h4[0] = mk(0, 1, 2, 4, 5, 6, 8, 9, 10);
        h4[1] = mk(1, 2, 3, 5, 6, 7, 9, 10, 11);
        h4[2] = mk(4, 5, 6, 8, 9, 10, 12, 13, 14);
        h4[3] = mk(5, 6, 7, 9, 10, 11, 13, 14, 15);
        h4[4] = mk(100, 101, 102, 104, 105, 106, 108, 109, 110);
        h4[5] = mk(101, 102, 103, 105, 106, 107, 109, 110, 111);
        h4[6] = mk(104, 105, 106, 108, 109, 110, 112, 113, 114);
        h4[7] = mk(105, 106, 107, 109, 110, 111, 113, 114, 115);
        h5[0] = mk(-128, 127, -128, 127, -128, 127, -128, 127, -128);
        h5[1] = mk(127, -128, 127, -128, 127, -128, 127, -128, 127);
        h5[2] = mk(-128, 127, -128, 127, -128, 127, -128, 127, -128);

        for (int k = 0; k < 3; k++) do_reset(k);

        hidx[0] = 0;
        for (int i = 0; i < 16; i++) pix(0, i);
        idle(0);

        hidx[0] = 0;
        for (int i = 0; i < 16; i++) begin
            pix(0, i);
            idle(0);
        end

        hidx[0] = 0;
        for (int i = 0; i < 16; i++) pix(0, i);
        for (int i = 0; i < 16; i++) pix(0, 100 + i);
        idle(0);

        hidx[0] = 0;
        for (int i = 0; i < 8; i++) pix(0, i);
        do_reset(0);
        for (int i = 0; i < 16; i++) pix(0, i);
        idle(0);

        hidx[1] = 0;
        for (int i = 0; i < 15; i++) pix(1, (i % 2 == 0) ? -128 : 127);
        idle(1);

        for (int i = 0; i < 784; i++) pix(2, int'($urandom_range(0, 255)));
        idle(2);

        repeat (4) @(negedge clk);
        chk("queues_empty", 0, 80'(qsize(0) + qsize(1) + qsize(2)), 80'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels (legal range 3..1024).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, in_data is presented this cycle.
REQ-006 SHALL have port in_data, input, 8, signed pixel, raster order (row-major, col 0 first).
REQ-007 SHALL have ports win0..win8, output, 8 each, signed 3x3 window, row-major: win0 = top-left (r-2,c-2), win4 = centre (r-1,c-1), win8 = bottom-right (r,c).
REQ-008 SHALL have port out_valid, output, 1, win0..win8 hold a complete window this cycle.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse coincident with the last window of a frame.

Function
REQ-010 SHALL accept one pixel on every cycle with in_valid=1; there is no backpressure; in_valid=0 cycles are bubbles and change no state except clearing out_valid/frame_done.
REQ-011 SHALL track position with a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), advanced only on accepted pixels; col wraps to 0 and increments row at IMG_W-1; row wraps to 0 after (IMG_H-1, IMG_W-1), starting a new frame.
REQ-012 SHALL store the previous two image rows in two line buffers of IMG_W entries each, plus a 3x3 shift-register window fed by (line1[c], line0[c], in_data).
REQ-013 SHALL assert out_valid exactly one cycle after an accepted pixel at (r,c) with r>=2 and c>=2, windows only (no padding); no window straddles row boundaries or frames.
REQ-014 SHALL produce exactly (IMG_H-2)*(IMG_W-2) windows per frame.
REQ-015 SHALL hold win0..win8 stable when out_valid=0; values are don't-care for checking but SHALL NOT be X after reset.
REQ-016 SHALL pass pixel values unmodified (no saturation, rounding or sign change); -128 and 127 propagate bit-exact.
REQ-017 SHALL assert frame_done in the same cycle as the out_valid of window (IMG_H-1, IMG_W-1).
REQ-018 SHALL treat back-to-back frames with zero gap correctly: the first pixel after the frame wrap is (0,0) and no window is emitted until that frame's (2,2).
REQ-019 SHALL exhibit a fixed latency of 1 cycle from accepting the pixel at (r,c) to the corresponding out_valid, independent of bubbles.

Reset
REQ-020 SHALL, while rst=1, set out_valid=0, frame_done=0, win0..win8=0, column and row counters=0.
REQ-021 SHALL ignore in_valid during rst=1; the first pixel accepted after rst deasserts is (0,0).
REQ-022 SHALL, on reset mid-frame, discard the partial frame; line-buffer contents need not be cleared, since REQ-013 gating prevents stale data from being emitted.

Verification
REQ-023 SHALL: IMG_W=IMG_H=4, pixels 0..15 continuous -> out_valid first 1 cycle after pixel 10, window 0,1,2,4,5,6,8,9,10; 4 windows total; last window 5,6,7,9,10,11,13,14,15 with frame_done=1.
REQ-024 SHALL: same frame with in_valid toggled 1,0,1,0... -> identical 4 windows in the same order, each 1 cycle after its triggering pixel.
REQ-025 SHALL: two 4x4 frames back-to-back (0..15, then 100..115) -> 8 windows; the first window of frame 2 is 100,101,102,104,105,106,108,109,110, with no window mixing frames.
REQ-026 SHALL: rst pulsed after pixel 7, then pixels 0..15 -> no out_valid before the new pixel 10; output identical to REQ-023.
REQ-027 SHALL: IMG_W=5, IMG_H=3, pixels alternating -128/127 -> exactly 3 windows, bit-exact signed values, frame_done on the third.
REQ-028 SHALL: default 28x28 random frame -> 676 windows matching a golden raster model, frame_done once.
